// File: rtl/wb_write_queue_if.sv
// Bus bundle for the writeback write queue: producer A/B requests, register-file
// write port, two forwarding lookups and queue occupancy status.
interface wb_write_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          A_Valid;
   logic [AW-1:0] A_Reg;
   logic [DW-1:0] A_Data;
   logic          A_Ready;

   logic          B_Valid;
   logic [AW-1:0] B_Reg;
   logic [DW-1:0] B_Data;
   logic          B_Ready;

   logic          RegWre;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;

   logic [AW-1:0] LkReg1;
   logic          LkHit1;
   logic [DW-1:0] LkData1;
   logic [AW-1:0] LkReg2;
   logic          LkHit2;
   logic [DW-1:0] LkData2;

   logic [CW-1:0] Count;
   logic          Full;
   logic          Empty;

   // Producers, decode lookups and the register file sit on the master side.
   modport master (
      output A_Valid, A_Reg, A_Data, input A_Ready,
      output B_Valid, B_Reg, B_Data, input B_Ready,
      input  RegWre, WriteReg, WriteData,
      output LkReg1, input LkHit1, LkData1,
      output LkReg2, input LkHit2, LkData2,
      input  Count, Full, Empty
   );

   modport slave (
      input  A_Valid, A_Reg, A_Data, output A_Ready,
      input  B_Valid, B_Reg, B_Data, output B_Ready,
      output RegWre, WriteReg, WriteData,
      input  LkReg1, output LkHit1, LkData1,
      input  LkReg2, output LkHit2, LkData2,
      output Count, Full, Empty
   );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback write queue: merges two producers into an in-order FIFO that retires one
// register-file write per cycle, with combinational forwarding of pending writes.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input logic              CLK,
   input logic              RST,
   wb_write_queue_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] reg_mem_q  [DEPTH];
   logic [AW-1:0] reg_mem_d  [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];
   logic [DW-1:0] data_mem_d [DEPTH];

   logic          reg_wre_q, reg_wre_d;
   logic [AW-1:0] write_reg_q, write_reg_d;
   logic [DW-1:0] write_data_q, write_data_d;

   logic          a_ready, b_ready;
   logic          enq_a, enq_b, pop;
   logic [PW-1:0] b_slot;
   logic [DW:0]   lk1, lk2;

   // Ready looks only at the registered count; a same-cycle pop earns no credit.
   always_comb begin
      a_ready = RST && (count_q <= CW'(DEPTH - 1));
      enq_a   = bus.A_Valid && a_ready && (bus.A_Reg != '0);
      b_ready = RST && ((count_q <= CW'(DEPTH - 2)) ||
                        ((count_q == CW'(DEPTH - 1)) && !enq_a));
      enq_b   = bus.B_Valid && b_ready && (bus.B_Reg != '0);
      pop     = (count_q != '0);
   end

   always_comb begin
      reg_mem_d  = reg_mem_q;
      data_mem_d = data_mem_q;
      b_slot     = enq_a ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      if (enq_a) begin
         reg_mem_d[wr_ptr_q]  = bus.A_Reg;
         data_mem_d[wr_ptr_q] = bus.A_Data;
      end
      if (enq_b) begin
         reg_mem_d[b_slot]  = bus.B_Reg;
         data_mem_d[b_slot] = bus.B_Data;
      end
      wr_ptr_d = wr_ptr_q + PW'(enq_a) + PW'(enq_b);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(enq_a) + CW'(enq_b) - CW'(pop);

      reg_wre_d    = pop;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (pop) begin
         write_reg_d  = reg_mem_q[rd_ptr_q];
         write_data_d = data_mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         reg_wre_q    <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         reg_wre_q    <= reg_wre_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Slot storage needs no reset: occupancy is tracked by count and pointers.
   always_ff @(posedge CLK) begin
      reg_mem_q  <= reg_mem_d;
      data_mem_q <= data_mem_d;
   end

   // Scan oldest to youngest so the last match overrides: output register first,
   // then queue entries from head toward tail.
   function automatic logic [DW:0] lookup(input logic [AW-1:0] key);
      logic          hit;
      logic [DW-1:0] data;
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      if (key != '0) begin
         if (reg_wre_q && (write_reg_q == key)) begin
            hit  = 1'b1;
            data = write_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (reg_mem_q[idx] == key)) begin
               hit  = 1'b1;
               data = data_mem_q[idx];
            end
         end
      end
      return {hit, data};
   endfunction

   always_comb begin
      lk1 = lookup(bus.LkReg1);
      lk2 = lookup(bus.LkReg2);
   end

   assign bus.A_Ready   = a_ready;
   assign bus.B_Ready   = b_ready;
   assign bus.RegWre    = reg_wre_q;
   assign bus.WriteReg  = write_reg_q;
   assign bus.WriteData = write_data_q;
   assign bus.LkHit1    = lk1[DW];
   assign bus.LkData1   = lk1[DW-1:0];
   assign bus.LkHit2    = lk2[DW];
   assign bus.LkData2   = lk2[DW-1:0];
   assign bus.Count     = count_q;
   assign bus.Full      = (count_q == CW'(DEPTH));
   assign bus.Empty     = (count_q == '0);
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted writes are queued as expected port
// traffic, and ready/count/lookup outputs are compared against a small occupancy model.
module tb_wb_write_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   wr_t  exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   m_cnt = 0;
   logic m_wre = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW:0] lk_model(input logic [AW-1:0] key);
      logic [DW:0] res;
      res = '0;
      if (key != '0)
         foreach (exp_q[i])
            if (exp_q[i].r == key) res = {1'b1, exp_q[i].d};
      return res;
   endfunction

   // Outputs settle mid-cycle; inputs were driven just after the previous posedge.
   always @(negedge clk) begin
      logic        ea_rdy, eb_rdy, ea_enq, eb_enq;
      logic [DW:0] lk1, lk2;
      wr_t         e;
      ea_rdy = rst_n && (m_cnt <= DEPTH - 1);
      ea_enq = bus.A_Valid && ea_rdy && (bus.A_Reg != '0);
      eb_rdy = rst_n && ((m_cnt <= DEPTH - 2) || ((m_cnt == DEPTH - 1) && !ea_enq));
      eb_enq = bus.B_Valid && eb_rdy && (bus.B_Reg != '0);

      chk("a_ready", 64'(bus.A_Ready), 64'(ea_rdy));
      chk("b_ready", 64'(bus.B_Ready), 64'(eb_rdy));
      chk("count",   64'(bus.Count),   64'(m_cnt));
      chk("full",    64'(bus.Full),    64'(m_cnt == DEPTH));
      chk("empty",   64'(bus.Empty),   64'(m_cnt == 0));

      lk1 = lk_model(bus.LkReg1);
      lk2 = lk_model(bus.LkReg2);
      chk("lk1_hit",  64'(bus.LkHit1),  64'(lk1[DW]));
      chk("lk1_data", 64'(bus.LkData1), 64'(lk1[DW-1:0]));
      chk("lk2_hit",  64'(bus.LkHit2),  64'(lk2[DW]));
      chk("lk2_data", 64'(bus.LkData2), 64'(lk2[DW-1:0]));

      chk("regwre", 64'(bus.RegWre), 64'(m_wre));
      if (bus.RegWre) begin
         if (exp_q.size() == 0) begin
            chk("spurious_wr", 64'(bus.RegWre), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("wr_reg",  64'(bus.WriteReg),  64'(e.r));
            chk("wr_data", 64'(bus.WriteData), 64'(e.d));
         end
      end

      if (!rst_n) begin
         exp_q.delete();
         m_cnt = 0;
         m_wre = 1'b0;
      end else begin
         m_wre = (m_cnt > 0);
         if (ea_enq) begin
            e.r = bus.A_Reg;
            e.d = bus.A_Data;
            exp_q.push_back(e);
         end
         if (eb_enq) begin
            e.r = bus.B_Reg;
            e.d = bus.B_Data;
            exp_q.push_back(e);
         end
         m_cnt = m_cnt + int'(ea_enq) + int'(eb_enq) - ((m_cnt > 0) ? 1 : 0);
      end
   end

   task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd);
      bus.A_Valid = av;
      bus.A_Reg   = ar;
      bus.A_Data  = ad;
      bus.B_Valid = bv;
      bus.B_Reg   = br;
      bus.B_Data  = bd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   initial begin
      bus.A_Valid = 1'b0;
      bus.A_Reg   = '0;
      bus.A_Data  = '0;
      bus.B_Valid = 1'b0;
      bus.B_Reg   = '0;
      bus.B_Data  = '0;
      bus.LkReg1  = '0;
      bus.LkReg2  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_wreg",  64'(bus.WriteReg),  64'(0));
      chk("rst_wdata", 64'(bus.WriteData), 64'(0));
      chk("rst_wre",   64'(bus.RegWre),    64'(0));

      // Single write: visible on the port after the second edge, for one cycle.
      drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
      idle(4);

      // Same-register A/B pair: A retires first, lookup sees B throughout.
      bus.LkReg1 = 5'd3;
      drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
      idle(4);

      // Both producers every cycle with distinct registers.
      for (int i = 0; i < 8; i++)
         drive(1'b1, AW'(1 + i), DW'($urandom), 1'b1, AW'(16 + i), DW'($urandom));
      idle(6);

      // Writes to r0 handshake but are discarded.
      bus.LkReg1 = 5'd0;
      drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
      idle(2);

      // Three queued entries flushed by a one-cycle reset.
      drive(1'b1, 5'd9,  32'h91, 1'b1, 5'd10, 32'h92);
      drive(1'b1, 5'd11, 32'h93, 1'b1, 5'd12, 32'h94);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("flush_count", 64'(bus.Count),     64'(0));
      chk("flush_empty", 64'(bus.Empty),     64'(1));
      chk("flush_wre",   64'(bus.RegWre),    64'(0));
      chk("flush_wreg",  64'(bus.WriteReg),  64'(0));
      chk("flush_wdata", 64'(bus.WriteData), 64'(0));
      idle(4);

      // Two writes to r7: lookup returns the younger, then clears once both retire.
      bus.LkReg2 = 5'd7;
      drive(1'b1, 5'd7, 32'd1, 1'b0, '0, '0);
      drive(1'b1, 5'd7, 32'd2, 1'b0, '0, '0);
      idle(5);
      chk("r7_hit_gone", 64'(bus.LkHit2), 64'(0));

      // Random traffic with one mid-run reset.
      for (int i = 0; i < 60; i++) begin
         bus.LkReg1 = AW'($urandom_range(0, 31));
         bus.LkReg2 = AW'($urandom_range(0, 7));
         rst_n = (i != 30);
         drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      end
      rst_n = 1'b1;
      idle(8);
      chk("leftover", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
